cpu_ldst_bridge: RTL and testbench
==================================

CPU_LDST_BRIDGE -- requirements
Module: cpu_ldst_bridge

Interface
REQ-001 SHALL have parameter RAM_AW, default 15, meaning RAM word-address width (RAM region 0x0000-0x7FFF).
REQ-002 SHALL have parameter SW_W, default 10, meaning switch/LED width.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-005 SHALL have CPU-side ports: i_ldst_addr in 16; i_ldst_rd in 1; i_ldst_wr in 1; i_ldst_wrdata in 16; o_ldst_rddata out 16.
REQ-006 SHALL have RAM-side ports: o_mem_addr out RAM_AW; o_mem_rd out 1; o_mem_wr out 1; o_mem_wrdata out 16; i_mem_rddata in 16, valid exactly one cycle after o_mem_rd.
REQ-007 SHALL have board ports: i_sw in SW_W (asynchronous); o_leds out SW_W; o_hex out 16; o_timer_irq out 1.

Function
REQ-008 SHALL decode i_ldst_addr combinationally: addr[15]=0 RAM; 0xA000 LED; 0xB000 HEX; 0xC000 SW; 0xD000 TCTRL; 0xD002 TLOAD; 0xD004 TCOUNT; any other address unmapped.
REQ-009 SHALL, for a RAM access, drive o_mem_addr=addr[RAM_AW-1:0], o_mem_rd/o_mem_wr/o_mem_wrdata combinationally in the same cycle; o_mem_rd/o_mem_wr SHALL be 0 for non-RAM addresses.
REQ-010 SHALL present read data on o_ldst_rddata exactly one cycle after the i_ldst_rd cycle, for every region.
REQ-011 SHALL register the decoded region of a read in the request cycle and use it the next cycle to select i_mem_rddata (RAM) or a registered peripheral read value.
REQ-012 SHALL sample peripheral read values (LED, HEX, synced SW zero-extended, TCTRL, TLOAD, TCOUNT) in the request cycle, i.e. the value before any same-cycle update.
REQ-013 SHALL return 0x0000 for unmapped reads and for cycles following no read; unmapped writes SHALL have no effect.
REQ-014 SHALL, when i_ldst_rd and i_ldst_wr are both high, perform the write only and treat the read as not issued.
REQ-015 SHALL update LED (low SW_W bits) and HEX registers on write; o_leds/o_hex reflect them the cycle after the write.
REQ-016 SHALL pass i_sw through a 2-flop synchronizer; SW reads return the second-stage value.
REQ-017 SHALL implement TCTRL bits: [0] EN, [1] RELOAD, [2] FLAG (read-only set, write-1-to-clear); other bits read 0.
REQ-018 SHALL decrement TCOUNT by 1 each cycle while EN=1 and TCOUNT!=0.
REQ-019 SHALL, when EN=1 and TCOUNT=1, set FLAG next cycle and load TLOAD if RELOAD=1, else go to 0 and clear EN.
REQ-020 SHALL, on a TLOAD write while EN=0, also load TCOUNT with the written value; while EN=1 only TLOAD changes.
REQ-021 SHALL give FLAG set priority over a same-cycle write-1-to-clear.
REQ-022 SHALL, when EN=1 and TLOAD=0, hold TCOUNT at 0 with no FLAG set.
REQ-023 SHALL drive o_timer_irq = FLAG.

Reset
REQ-024 SHALL on reset asynchronously clear: o_ldst_rddata, registered region, LED, HEX, synchronizer flops, TCTRL, TLOAD, TCOUNT to 0; o_leds=0, o_hex=0, o_timer_irq=0.
REQ-025 SHALL, for a read issued in the cycle reset asserts, return 0 and drop the pending read.

Configuration
REQ-026 SHALL, with macro CPU_LDST_BRIDGE_TIMER_EN defined, include the timer (REQ-017..023).
REQ-027 SHALL, without CPU_LDST_BRIDGE_TIMER_EN, omit timer logic: 0xD000-0xD004 behave as unmapped, o_timer_irq tied 0.

Verification
REQ-028 SHALL cover: write 0x1234 to 0x0010 then read 0x0010 -> o_mem_wr=1 addr 0x0010 same cycle; o_ldst_rddata=0x1234 one cycle after read.
REQ-029 SHALL cover: write 0x03FF to 0xA000 -> o_leds=0x3FF next cycle; read 0xA000 -> 0x03FF one cycle later; o_mem_wr stays 0.
REQ-030 SHALL cover: i_sw=0x155 held -> read 0xC000 issued 2 cycles later returns 0x0155; issued 1 cycle later returns old value.
REQ-031 SHALL cover (TIMER_EN): TLOAD=3, TCTRL=0x3 -> TCOUNT 3,2,1,3,...; o_timer_irq=1 the cycle after count 1; write 0x4 to TCTRL clears it, except when coinciding with a set.
REQ-032 SHALL cover: rd+wr same cycle to 0xB000 with 0x00AB -> o_hex=0x00AB, next-cycle o_ldst_rddata=0; read 0x9000 -> 0x0000.
REQ-033 SHALL cover: reset asserted mid-read and mid-count -> all outputs 0 immediately, timer stopped after release.

Source files
------------

// File: rtl/cpu_ldst_bridge_if.sv
// CPU load/store and RAM-side signal bundle for cpu_ldst_bridge.
// The slave modport is the bridge's view; master is the CPU/RAM environment.
interface cpu_ldst_bridge_if #(
  parameter int unsigned RAM_AW = 15
);
  logic [15:0]       i_ldst_addr;
  logic              i_ldst_rd;
  logic              i_ldst_wr;
  logic [15:0]       i_ldst_wrdata;
  logic [15:0]       o_ldst_rddata;
  logic [RAM_AW-1:0] o_mem_addr;
  logic              o_mem_rd;
  logic              o_mem_wr;
  logic [15:0]       o_mem_wrdata;
  logic [15:0]       i_mem_rddata;

  modport slave (
    input  i_ldst_addr, i_ldst_rd, i_ldst_wr, i_ldst_wrdata, i_mem_rddata,
    output o_ldst_rddata, o_mem_addr, o_mem_rd, o_mem_wr, o_mem_wrdata
  );

  modport master (
    output i_ldst_addr, i_ldst_rd, i_ldst_wr, i_ldst_wrdata, i_mem_rddata,
    input  o_ldst_rddata, o_mem_addr, o_mem_rd, o_mem_wr, o_mem_wrdata
  );
endinterface

// File: rtl/cpu_ldst_bridge.sv
// Load/store bridge: RAM pass-through plus LED, HEX, switch and timer registers.
// Timer is included only when CPU_LDST_BRIDGE_TIMER_EN is defined.
module cpu_ldst_bridge #(
  parameter int unsigned RAM_AW = 15,
  parameter int unsigned SW_W   = 10
) (
  input  logic            clk,
  input  logic            reset,
  cpu_ldst_bridge_if.slave bus,
  input  logic [SW_W-1:0] i_sw,
  output logic [SW_W-1:0] o_leds,
  output logic [15:0]     o_hex,
  output logic            o_timer_irq
);
  localparam int unsigned DW = 16;

  typedef enum logic [2:0] {
    SEL_NONE, SEL_RAM, SEL_LED, SEL_HEX, SEL_SW, SEL_TCTRL, SEL_TLOAD, SEL_TCOUNT
  } sel_e;

  typedef enum logic [1:0] {RD_NONE, RD_RAM, RD_PERIPH} rd_e;

  sel_e            sel_c;
  logic            rd_go_c;
  logic            wr_go_c;
  logic [DW-1:0]   periph_c;
  rd_e             rd_q;
  logic [DW-1:0]   prd_q;
  logic [SW_W-1:0] led_q;
  logic [DW-1:0]   hex_q;
  logic [SW_W-1:0] sw_s1;
  logic [SW_W-1:0] sw_s2;

  // A simultaneous read and write is treated as a write only
  assign rd_go_c = bus.i_ldst_rd & ~bus.i_ldst_wr;
  assign wr_go_c = bus.i_ldst_wr;

  always_comb begin
    sel_c = SEL_NONE;
    if (!bus.i_ldst_addr[15]) begin
      sel_c = SEL_RAM;
    end else begin
      case (bus.i_ldst_addr)
        16'hA000: sel_c = SEL_LED;
        16'hB000: sel_c = SEL_HEX;
        16'hC000: sel_c = SEL_SW;
`ifdef CPU_LDST_BRIDGE_TIMER_EN
        16'hD000: sel_c = SEL_TCTRL;
        16'hD002: sel_c = SEL_TLOAD;
        16'hD004: sel_c = SEL_TCOUNT;
`endif
        default:  sel_c = SEL_NONE;
      endcase
    end
  end

  assign bus.o_mem_addr   = bus.i_ldst_addr[RAM_AW-1:0];
  assign bus.o_mem_rd     = (sel_c == SEL_RAM) && rd_go_c;
  assign bus.o_mem_wr     = (sel_c == SEL_RAM) && wr_go_c;
  assign bus.o_mem_wrdata = bus.i_ldst_wrdata;

`ifdef CPU_LDST_BRIDGE_TIMER_EN
  logic          t_en;
  logic          t_reload;
  logic          t_flag;
  logic [DW-1:0] t_load;
  logic [DW-1:0] t_count;
  logic          tick_c;
  logic          wr_tctrl_c;
  logic          wr_tload_c;

  assign tick_c     = t_en && (t_count == DW'(1));
  assign wr_tctrl_c = wr_go_c && (sel_c == SEL_TCTRL);
  assign wr_tload_c = wr_go_c && (sel_c == SEL_TLOAD);

  // Countdown timer; later assignments give CPU writes precedence over the count path
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t_en     <= 1'b0;
      t_reload <= 1'b0;
      t_flag   <= 1'b0;
      t_load   <= '0;
      t_count  <= '0;
    end else begin
      if (t_en && (t_count != '0)) begin
        if (tick_c) begin
          if (t_reload) begin
            t_count <= t_load;
          end else begin
            t_count <= '0;
            t_en    <= 1'b0;
          end
        end else begin
          t_count <= t_count - DW'(1);
        end
      end
      if (wr_tload_c) begin
        t_load <= bus.i_ldst_wrdata;
        if (!t_en) t_count <= bus.i_ldst_wrdata;
      end
      if (wr_tctrl_c) begin
        t_en     <= bus.i_ldst_wrdata[0];
        t_reload <= bus.i_ldst_wrdata[1];
      end
      // Terminal count beats a same-cycle write-1-to-clear
      if (tick_c) t_flag <= 1'b1;
      else if (wr_tctrl_c && bus.i_ldst_wrdata[2]) t_flag <= 1'b0;
    end
  end

  assign o_timer_irq = t_flag;
`else
  assign o_timer_irq = 1'b0;
`endif

  always_comb begin
    periph_c = '0;
    case (sel_c)
      SEL_LED:    periph_c = DW'(led_q);
      SEL_HEX:    periph_c = hex_q;
      SEL_SW:     periph_c = DW'(sw_s2);
`ifdef CPU_LDST_BRIDGE_TIMER_EN
      SEL_TCTRL:  periph_c = {13'd0, t_flag, t_reload, t_en};
      SEL_TLOAD:  periph_c = t_load;
      SEL_TCOUNT: periph_c = t_count;
`endif
      default:    periph_c = '0;
    endcase
  end

  // Request-cycle capture of read source and peripheral value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q  <= RD_NONE;
      prd_q <= '0;
    end else begin
      prd_q <= '0;
      if (!rd_go_c || (sel_c == SEL_NONE)) begin
        rd_q <= RD_NONE;
      end else if (sel_c == SEL_RAM) begin
        rd_q <= RD_RAM;
      end else begin
        rd_q  <= RD_PERIPH;
        prd_q <= periph_c;
      end
    end
  end

  always_comb begin
    bus.o_ldst_rddata = '0;
    case (rd_q)
      RD_RAM:    bus.o_ldst_rddata = bus.i_mem_rddata;
      RD_PERIPH: bus.o_ldst_rddata = prd_q;
      default:   bus.o_ldst_rddata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q <= '0;
      hex_q <= '0;
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= i_sw;
      sw_s2 <= sw_s1;
      if (wr_go_c && (sel_c == SEL_LED)) led_q <= bus.i_ldst_wrdata[SW_W-1:0];
      if (wr_go_c && (sel_c == SEL_HEX)) hex_q <= bus.i_ldst_wrdata;
    end
  end

  assign o_leds = led_q;
  assign o_hex  = hex_q;
endmodule

// File: tb/tb_cpu_ldst_bridge.sv
// Directed bench for cpu_ldst_bridge: RAM path, LED/HEX/SW registers, timer, reset.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_cpu_ldst_bridge;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  i_sw = '0;
  logic [9:0]  o_leds;
  logic [15:0] o_hex;
  logic        o_timer_irq;
  logic [15:0] ram [0:255];
  int          n_tests = 0;
  int          n_fail  = 0;

  cpu_ldst_bridge_if #(.RAM_AW(15)) bus ();

  cpu_ldst_bridge #(.RAM_AW(15), .SW_W(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .i_sw        (i_sw),
    .o_leds      (o_leds),
    .o_hex       (o_hex),
    .o_timer_irq (o_timer_irq)
  );

  always #5 clk = ~clk;

  // External RAM: read data valid one cycle after o_mem_rd, garbage otherwise
  always @(posedge clk) begin
    if (bus.o_mem_wr) ram[bus.o_mem_addr[7:0]] <= bus.o_mem_wrdata;
    bus.i_mem_rddata <= bus.o_mem_rd ? ram[bus.o_mem_addr[7:0]] : 16'hDEAD;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic rd, input logic wr, input logic [15:0] d);
    @(negedge clk);
    bus.i_ldst_addr   = a;
    bus.i_ldst_rd     = rd;
    bus.i_ldst_wr     = wr;
    bus.i_ldst_wrdata = d;
    #1;
  endtask

  task automatic idle();
    drive(16'h0000, 1'b0, 1'b0, 16'h0000);
  endtask

`ifdef CPU_LDST_BRIDGE_TIMER_EN
  logic [15:0] cnt_exp [0:2];
  logic        irq_exp [0:2];
`endif

  initial begin
    bus.i_ldst_addr   = '0;
    bus.i_ldst_rd     = 1'b0;
    bus.i_ldst_wr     = 1'b0;
    bus.i_ldst_wrdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_rddata", 32'(bus.o_ldst_rddata), 32'h0);
    check("rst_leds", 32'(o_leds), 32'h0);
    check("rst_hex", 32'(o_hex), 32'h0);
    check("rst_irq", 32'(o_timer_irq), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // RAM write then read
    drive(16'h0010, 1'b0, 1'b1, 16'h1234);
    check("ram_wr", 32'(bus.o_mem_wr), 32'h1);
    check("ram_wr_rd", 32'(bus.o_mem_rd), 32'h0);
    check("ram_addr", 32'(bus.o_mem_addr), 32'h0010);
    check("ram_wrdata", 32'(bus.o_mem_wrdata), 32'h1234);
    drive(16'h0010, 1'b1, 1'b0, 16'h0000);
    check("ram_rd", 32'(bus.o_mem_rd), 32'h1);
    idle();
    check("ram_rddata", 32'(bus.o_ldst_rddata), 32'h1234);
    idle();
    check("no_read", 32'(bus.o_ldst_rddata), 32'h0);

    // LED write/read
    drive(16'hA000, 1'b0, 1'b1, 16'h03FF);
    check("led_mem_wr", 32'(bus.o_mem_wr), 32'h0);
    drive(16'hA000, 1'b1, 1'b0, 16'h0000);
    check("led_out", 32'(o_leds), 32'h3FF);
    check("led_mem_rd", 32'(bus.o_mem_rd), 32'h0);
    idle();
    check("led_rd", 32'(bus.o_ldst_rddata), 32'h03FF);

    // Switch synchronizer latency
    i_sw = 10'h155;
    drive(16'hC000, 1'b1, 1'b0, 16'h0000);
    drive(16'hC000, 1'b1, 1'b0, 16'h0000);
    check("sw_old", 32'(bus.o_ldst_rddata), 32'h0);
    idle();
    check("sw_new", 32'(bus.o_ldst_rddata), 32'h0155);

    // Read+write collision, unmapped accesses
    drive(16'hB000, 1'b1, 1'b1, 16'h00AB);
    idle();
    check("hex_out", 32'(o_hex), 32'h00AB);
    check("rdwr_rddata", 32'(bus.o_ldst_rddata), 32'h0);
    drive(16'h9000, 1'b1, 1'b0, 16'h0000);
    drive(16'h9000, 1'b0, 1'b1, 16'hFFFF);
    check("unmap_rd", 32'(bus.o_ldst_rddata), 32'h0);
    check("unmap_mem_wr", 32'(bus.o_mem_wr), 32'h0);
    drive(16'hB000, 1'b1, 1'b0, 16'h0000);
    check("unmap_leds", 32'(o_leds), 32'h3FF);
    check("unmap_hex", 32'(o_hex), 32'h00AB);
    idle();
    check("hex_rd", 32'(bus.o_ldst_rddata), 32'h00AB);

`ifdef CPU_LDST_BRIDGE_TIMER_EN
    cnt_exp[0] = 16'd3; cnt_exp[1] = 16'd2; cnt_exp[2] = 16'd1;
    irq_exp[0] = 1'b0;  irq_exp[1] = 1'b0;  irq_exp[2] = 1'b1;
    drive(16'hD002, 1'b0, 1'b1, 16'd3);
    drive(16'hD000, 1'b0, 1'b1, 16'h0003);
    drive(16'hD004, 1'b1, 1'b0, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      drive(16'hD004, 1'b1, 1'b0, 16'h0000);
      check($sformatf("tcount_%0d", k), 32'(bus.o_ldst_rddata), 32'(cnt_exp[k]));
      check($sformatf("tirq_%0d", k), 32'(o_timer_irq), 32'(irq_exp[k]));
    end
    drive(16'hD000, 1'b0, 1'b1, 16'h0007);
    check("tcount_reload", 32'(bus.o_ldst_rddata), 32'd3);
    check("tirq_held", 32'(o_timer_irq), 32'h1);
    drive(16'hD000, 1'b0, 1'b1, 16'h0007);
    check("tirq_cleared", 32'(o_timer_irq), 32'h0);
    drive(16'hD000, 1'b0, 1'b1, 16'h0004);
    check("tirq_set_wins", 32'(o_timer_irq), 32'h1);
    drive(16'hD004, 1'b1, 1'b0, 16'h0000);
    check("tirq_stop_clr", 32'(o_timer_irq), 32'h0);
    drive(16'hD004, 1'b1, 1'b0, 16'h0000);
    check("tcount_stop0", 32'(bus.o_ldst_rddata), 32'd2);
    idle();
    check("tcount_stop1", 32'(bus.o_ldst_rddata), 32'd2);
    // Leave the timer running into the reset test
    drive(16'hD002, 1'b0, 1'b1, 16'd5);
    drive(16'hD000, 1'b0, 1'b1, 16'h0003);
    idle();
`else
    drive(16'hD000, 1'b0, 1'b1, 16'h0003);
    drive(16'hD000, 1'b1, 1'b0, 16'h0000);
    check("notmr_irq", 32'(o_timer_irq), 32'h0);
    drive(16'hD004, 1'b1, 1'b0, 16'h0000);
    check("notmr_tctrl", 32'(bus.o_ldst_rddata), 32'h0);
    idle();
    check("notmr_tcount", 32'(bus.o_ldst_rddata), 32'h0);
`endif

    // Reset mid-read and mid-count
    drive(16'hB000, 1'b1, 1'b0, 16'h0000);
    reset = 1'b1;
    #1;
    check("mid_rst_rddata", 32'(bus.o_ldst_rddata), 32'h0);
    check("mid_rst_leds", 32'(o_leds), 32'h0);
    check("mid_rst_hex", 32'(o_hex), 32'h0);
    check("mid_rst_irq", 32'(o_timer_irq), 32'h0);
    @(negedge clk);
    #1;
    check("rst_drop_read", 32'(bus.o_ldst_rddata), 32'h0);
    reset = 1'b0;
    idle();
    drive(16'hD004, 1'b1, 1'b0, 16'h0000);
    drive(16'hD000, 1'b1, 1'b0, 16'h0000);
    check("post_rst_tcount", 32'(bus.o_ldst_rddata), 32'h0);
    drive(16'hD004, 1'b1, 1'b0, 16'h0000);
    check("post_rst_tctrl", 32'(bus.o_ldst_rddata), 32'h0);
    idle();
    check("post_rst_tcount2", 32'(bus.o_ldst_rddata), 32'h0);
    check("post_rst_irq", 32'(o_timer_irq), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
